// File: rtl/vending_pkg.sv
// Shared vending types: coin values, dispenser FSM states, coin selection.
package vending_pkg;

  localparam logic [7:0] COIN_5  = 8'd5;
  localparam logic [7:0] COIN_10 = 8'd10;
  localparam logic [7:0] COIN_25 = 8'd25;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE
  } disp_state_t;

  typedef enum logic [1:0] {
    NONE,
    C5,
    C10,
    C25
  } coin_t;

  function automatic logic [7:0] coin_value(input coin_t c);
    logic [7:0] v;
    v = 8'd0;
    case (c)
      C5:      v = COIN_5;
      C10:     v = COIN_10;
      C25:     v = COIN_25;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  // Eject vector ordering is {25, 10, 5}.
  function automatic logic [2:0] coin_onehot(input coin_t c);
    logic [2:0] oh;
    oh = 3'b000;
    case (c)
      C5:      oh = 3'b001;
      C10:     oh = 3'b010;
      C25:     oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/change_dispenser_pulse_timer.sv
// Loadable down-counter with zero flag; times both eject pulses and gaps.
module pulse_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin payout: 25/10/5 hoppers, one registered eject pulse per coin,
// skipping hoppers that report empty.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       empty_25,
  input  logic       empty_10,
  input  logic       empty_5,
  output logic       eject_25,
  output logic       eject_10,
  output logic       eject_5,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic [7:0] remaining
);

  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  disp_state_t state, state_n;
  coin_t       coin, coin_n, sel;
  logic [2:0]  eject_q, eject_n;
  logic [7:0]  rem_q, rem_n;
  logic        short_q, short_n;
  logic        t_load, t_dec, t_zero;
  logic [CW-1:0] t_val;

  pulse_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  // Largest eligible coin; empties are only looked at while in SELECT.
  always_comb begin
    sel = NONE;
    if (!empty_25 && rem_q >= COIN_25)
      sel = C25;
    else if (!empty_10 && rem_q >= COIN_10)
      sel = C10;
    else if (!empty_5 && rem_q >= COIN_5)
      sel = C5;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      coin    <= NONE;
      eject_q <= 3'b000;
      rem_q   <= 8'd0;
      short_q <= 1'b0;
    end else begin
      state   <= state_n;
      coin    <= coin_n;
      eject_q <= eject_n;
      rem_q   <= rem_n;
      short_q <= short_n;
    end
  end

  always_comb begin
    state_n = state;
    coin_n  = coin;
    eject_n = 3'b000;
    rem_n   = rem_q;
    short_n = short_q;
    t_load  = 1'b0;
    t_val   = '0;
    t_dec   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          rem_n   = amount;
          short_n = 1'b0;
          state_n = S_SELECT;
        end
      end
      S_SELECT: begin
        if (rem_q == 8'd0) begin
          short_n = 1'b0;
          state_n = S_DONE;
        end else if (sel != NONE) begin
          // Eligibility already guarantees coin <= remaining.
          rem_n   = rem_q - coin_value(sel);
          coin_n  = sel;
          eject_n = coin_onehot(sel);
          t_load  = 1'b1;
          t_val   = CW'(PULSE_CYCLES - 1);
          state_n = S_PULSE;
        end else begin
          short_n = 1'b1;
          state_n = S_DONE;
        end
      end
      S_PULSE: begin
        if (t_zero) begin
          t_load  = 1'b1;
          t_val   = CW'(GAP_CYCLES - 1);
          state_n = S_GAP;
        end else begin
          eject_n = coin_onehot(coin);
          t_dec   = 1'b1;
        end
      end
      S_GAP: begin
        if (t_zero)
          state_n = S_SELECT;
        else
          t_dec = 1'b1;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign eject_25  = eject_q[2];
  assign eject_10  = eject_q[1];
  assign eject_5   = eject_q[0];
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign short     = short_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payout, empties, short change,
// start-while-busy and mid-pulse reset.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] amount;
  logic       empty_25, empty_10, empty_5;
  logic       eject_25, eject_10, eject_5;
  logic       busy, done, short;
  logic [7:0] remaining;

  int compared = 0;
  int mismatched = 0;

  int n25, n10, n5, len_bad, gap_bad, hot_bad, first_ej, done_cyc, rem_bad;

  always #5 clk = ~clk;

  change_dispenser #(.PULSE_CYCLES(4), .GAP_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount),
    .empty_25(empty_25), .empty_10(empty_10), .empty_5(empty_5),
    .eject_25(eject_25), .eject_10(eject_10), .eject_5(eject_5),
    .busy(busy), .done(done), .short(short), .remaining(remaining)
  );

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept a start at the next edge, leaving the bench #1 after that edge.
  task automatic kick(input logic [7:0] amt);
    amount = amt;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Watch the payout cycle by cycle until done (cycle 1 = first edge after
  // the accepting edge). Optionally re-pulse start at cycle poke_at.
  task automatic collect(input int poke_at, input logic [7:0] poke_amt,
                         input int rem_cap);
    logic [2:0] ej, prev;
    int run, zeros;
    bit had;
    n25 = 0; n10 = 0; n5 = 0; len_bad = 0; gap_bad = 0; hot_bad = 0;
    first_ej = -1; done_cyc = -1; rem_bad = 0;
    prev = 3'b000; run = 0; zeros = 0; had = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (i == poke_at) begin
        start  = 1'b1;
        amount = poke_amt;
      end
      ej = {eject_25, eject_10, eject_5};
      if (int'(remaining) > rem_cap) rem_bad++;
      if (ej != 3'b000 && !$onehot(ej)) hot_bad++;
      if (ej != 3'b000) begin
        if (prev == 3'b000) begin
          if (first_ej < 0) first_ej = i;
          if (had && zeros != 5) gap_bad++;
          had = 1'b1;
          run = 1;
          if (ej[2]) n25++;
          if (ej[1]) n10++;
          if (ej[0]) n5++;
        end else begin
          if (ej != prev) hot_bad++;
          run++;
        end
      end else begin
        if (prev != 3'b000) begin
          if (run != 4) len_bad++;
          zeros = 0;
        end
        zeros++;
      end
      prev = ej;
      if (done) begin
        done_cyc = i;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; amount = 8'd0;
    empty_25 = 1'b0; empty_10 = 1'b0; empty_5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_eject", {eject_25, eject_10, eject_5}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_short", short, 0);
    check("rst_rem", remaining, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 40 -> 25, 10, 5
    kick(8'd40);
    check("a40_busy", busy, 1);
    check("a40_rem_latched", remaining, 40);
    collect(-1, 8'd0, 40);
    check("a40_first_eject", first_ej, 1);
    check("a40_n25", n25, 1);
    check("a40_n10", n10, 1);
    check("a40_n5", n5, 1);
    check("a40_len", len_bad, 0);
    check("a40_gap", gap_bad, 0);
    check("a40_onehot", hot_bad, 0);
    check("a40_done_cyc", done_cyc, 28);
    check("a40_short", short, 0);
    check("a40_rem", remaining, 0);
    @(posedge clk); #1;
    check("a40_idle", busy, 0);
    check("a40_done_strobe", done, 0);

    // 50 with 25 empty -> five 10s
    empty_25 = 1'b1;
    kick(8'd50);
    collect(-1, 8'd0, 50);
    check("a50_n25", n25, 0);
    check("a50_n10", n10, 5);
    check("a50_n5", n5, 0);
    check("a50_len", len_bad, 0);
    check("a50_gap", gap_bad, 0);
    check("a50_done_cyc", done_cyc, 46);
    check("a50_short", short, 0);
    check("a50_rem", remaining, 0);
    empty_25 = 1'b0;
    @(posedge clk); #1;

    // 7 -> one 5, short by 2
    kick(8'd7);
    collect(-1, 8'd0, 7);
    check("a7_n5", n5, 1);
    check("a7_others", n25 + n10, 0);
    check("a7_done_cyc", done_cyc, 10);
    check("a7_short", short, 1);
    check("a7_rem", remaining, 2);
    repeat (3) @(posedge clk); #1;
    check("a7_short_held", short, 1);
    check("a7_rem_held", remaining, 2);

    // 30 with 10 and 5 empty -> one 25, short by 5
    empty_10 = 1'b1; empty_5 = 1'b1;
    kick(8'd30);
    check("a30_short_cleared", short, 0);
    collect(-1, 8'd0, 30);
    check("a30_n25", n25, 1);
    check("a30_others", n10 + n5, 0);
    check("a30_short", short, 1);
    check("a30_rem", remaining, 5);
    empty_10 = 1'b0; empty_5 = 1'b0;
    @(posedge clk); #1;

    // 0 -> immediate done, busy exactly two cycles
    kick(8'd0);
    check("a0_busy_c0", busy, 1);
    check("a0_done_c0", done, 0);
    collect(-1, 8'd0, 0);
    check("a0_done_cyc", done_cyc, 1);
    check("a0_busy_c1", busy, 1);
    check("a0_no_eject", n25 + n10 + n5, 0);
    check("a0_short", short, 0);
    @(posedge clk); #1;
    check("a0_busy_c2", busy, 0);

    // 25 with a second start (99) during the pulse: ignored
    kick(8'd25);
    collect(2, 8'd99, 25);
    check("a25_n25", n25, 1);
    check("a25_others", n10 + n5, 0);
    check("a25_rem_cap", rem_bad, 0);
    check("a25_done_cyc", done_cyc, 10);
    check("a25_rem", remaining, 0);
    @(posedge clk); #1;
    check("a25_no_requeue", busy, 0);
    amount = 8'd0;

    // 35 with reset during the second eject_25 cycle
    kick(8'd35);
    @(posedge clk); #1;
    check("rst35_eject_c1", eject_25, 1);
    check("rst35_rem", remaining, 10);
    @(posedge clk); #1;
    check("rst35_eject_c2", eject_25, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst35_eject", {eject_25, eject_10, eject_5}, 0);
    check("rst35_busy", busy, 0);
    check("rst35_done", done, 0);
    check("rst35_short", short, 0);
    check("rst35_rem", remaining, 0);
    @(posedge clk); #1;
    check("rst35_stays_idle", busy, 0);

    kick(8'd10);
    collect(-1, 8'd0, 10);
    check("a10_n10", n10, 1);
    check("a10_others", n25 + n5, 0);
    check("a10_first_eject", first_ej, 1);
    check("a10_len", len_bad, 0);
    check("a10_done_cyc", done_cyc, 10);
    check("a10_short", short, 0);
    check("a10_rem", remaining, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
